// File: rtl/adder_reg_if.sv
// Operand/result bundle for adder_reg. The master drives the operands and the slave (the adder) drives the results.
interface adder_reg_if #(
  parameter int SIZE = 8
);
  logic            valid_i;
  logic [SIZE-1:0] a_i;
  logic [SIZE-1:0] b_i;
  logic            carryin_i;
  logic [SIZE-1:0] result_o;
  logic            carryout_o;
  logic            valid_o;
  logic            zero_o;
  logic            overflow_o;

  modport master (
    output valid_i, a_i, b_i, carryin_i,
    input  result_o, carryout_o, valid_o, zero_o, overflow_o
  );

  modport slave (
    input  valid_i, a_i, b_i, carryin_i,
    output result_o, carryout_o, valid_o, zero_o, overflow_o
  );
endinterface

// File: rtl/adder_reg.sv
// Registered unsigned adder with carry in/out, a valid strobe, and zero and signed-overflow flags.
// Optional macro ADDER_REG_SATURATE_EN clamps the result to all ones on carry-out.
module adder_reg #(
  parameter int SIZE = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  adder_reg_if.slave  bus
);

  logic [SIZE:0]   full;
  logic [SIZE-1:0] sum_d;
  logic            ovf_d;

  logic [SIZE-1:0] result_d, result_q;
  logic            carry_d, carry_q;
  logic            zero_d, zero_q;
  logic            overflow_d, overflow_q;
  logic            valid_d, valid_q;

  assign full  = {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{SIZE{1'b0}}, bus.carryin_i};
  assign ovf_d = (bus.a_i[SIZE-1] == bus.b_i[SIZE-1]) && (full[SIZE-1] != bus.a_i[SIZE-1]);

`ifdef ADDER_REG_SATURATE_EN
  assign sum_d = full[SIZE] ? {SIZE{1'b1}} : full[SIZE-1:0];
`else
  assign sum_d = full[SIZE-1:0];
`endif

  // Data and flags hold on idle cycles so undriven operands never reach the outputs.
  always_comb begin
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    valid_d    = bus.valid_i;
    if (bus.valid_i) begin
      result_d   = sum_d;
      carry_d    = full[SIZE];
      zero_d     = (sum_d == '0);
      overflow_d = ovf_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.carryout_o = carry_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = overflow_q;
  assign bus.valid_o    = valid_q;

endmodule

// File: tb/tb_adder_reg.sv
// Self-checking bench for adder_reg (SIZE=8): directed boundaries, valid gating, async reset and random traffic
// compared against an integer-arithmetic reference model.
module tb_adder_reg;
  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails = 0;

  logic [SIZE-1:0] exp_res = '0;
  logic            exp_cy = 1'b0;
  logic            exp_v = 1'b0;
  logic            exp_z = 1'b0;
  logic            exp_ov = 1'b0;

  adder_reg_if #(.SIZE(SIZE)) bus_if ();

  adder_reg #(.SIZE(SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_res = '0; exp_cy = 1'b0; exp_v = 1'b0; exp_z = 1'b0; exp_ov = 1'b0;
  endtask

  // Reference: plain integer sums; overflow is the signed sum leaving the representable range.
  task automatic model_op(input logic v, input int a, input int b, input int c);
    int full, sa, sb, ssum, res;
    exp_v = v;
    if (v) begin
      full = a + b + c;
      sa   = (a >= 128) ? a - 256 : a;
      sb   = (b >= 128) ? b - 256 : b;
      ssum = sa + sb + c;
      res  = full % 256;
`ifdef ADDER_REG_SATURATE_EN
      if (full > 255) res = 255;
`endif
      exp_res = res[SIZE-1:0];
      exp_cy  = (full > 255);
      exp_z   = (res == 0);
      exp_ov  = (ssum > 127) || (ssum < -128);
    end
  endtask

  task automatic check_outputs(input string tag);
    checks += 5;
    assert (bus_if.result_o === exp_res) else begin
      fails++;
      $error("FAIL %s result_o: observed %h expected %h", tag, bus_if.result_o, exp_res);
    end
    assert (bus_if.carryout_o === exp_cy) else begin
      fails++;
      $error("FAIL %s carryout_o: observed %b expected %b", tag, bus_if.carryout_o, exp_cy);
    end
    assert (bus_if.valid_o === exp_v) else begin
      fails++;
      $error("FAIL %s valid_o: observed %b expected %b", tag, bus_if.valid_o, exp_v);
    end
    assert (bus_if.zero_o === exp_z) else begin
      fails++;
      $error("FAIL %s zero_o: observed %b expected %b", tag, bus_if.zero_o, exp_z);
    end
    assert (bus_if.overflow_o === exp_ov) else begin
      fails++;
      $error("FAIL %s overflow_o: observed %b expected %b", tag, bus_if.overflow_o, exp_ov);
    end
  endtask

  task automatic step(input string tag, input logic v, input int a, input int b, input int c);
    @(negedge clk);
    bus_if.valid_i   = v;
    bus_if.a_i       = a[SIZE-1:0];
    bus_if.b_i       = b[SIZE-1:0];
    bus_if.carryin_i = c[0];
    @(posedge clk);
    model_op(v, a, b, c);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bus_if.valid_i = 1'b0; bus_if.a_i = '0; bus_if.b_i = '0; bus_if.carryin_i = 1'b0;
    #1;
    check_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    step("bnd_ff_01",   1'b1, 'hFF, 'h01, 0);
    step("bnd_7f_01",   1'b1, 'h7F, 'h01, 0);
    step("bnd_80_80",   1'b1, 'h80, 'h80, 0);
    step("bnd_ff_ff_c", 1'b1, 'hFF, 'hFF, 1);
    step("bnd_zero",    1'b1, 'h00, 'h00, 0);
    step("sat_f0_20",   1'b1, 'hF0, 'h20, 0);
    step("cin_7f_00",   1'b1, 'h7F, 'h00, 1);

    step("gate_1", 1'b1, 'h12, 'h34, 0);
    step("gate_0a", 1'b0, 'h56, 'h78, 1);
    step("gate_0b", 1'b0, 'h9A, 'hBC, 0);
    step("gate_1b", 1'b1, 'hDE, 'h01, 1);

    // X on operands while idle must not disturb held outputs.
    @(negedge clk);
    bus_if.valid_i = 1'b0; bus_if.a_i = 'x; bus_if.b_i = 'x; bus_if.carryin_i = 1'bx;
    @(posedge clk);
    exp_v = 1'b0;
    #1;
    check_outputs("idle_x");

    step("pre_reset", 1'b1, 'h50, 'h0A, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_async");
    @(negedge clk);
    check_outputs("reset_held");
    rst = 1'b0;
    step("post_reset", 1'b1, 'h33, 'h44, 1);

    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step("random", v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
